oarb: RTL and testbench
=======================

Name: oarb

Overview:
- Output-port arbiter and flit forwarder of the switch, one instance per output port, directly downstream of the per-input ibsm stages.
- Collects each input's request bit for this output, grants one input round-robin and returns ack to that ibsm.
- Forwards the granted input's flits to the output link register until the tail flit passes, then releases the grant.

Parameters:
- None. Widths come from sw.vh: `PKTW=9 gives 10-bit flits, `PORT=3 gives 4 ports.
- Flit type is bits [9:8]: 00 = idle/none, 10 = head, 01 = body, 11 = tail.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  4  req[i] = input i requests this output (bit j of ibsm i's req)
- pkti  in  40  flits from inputs; input i on [10*i+9:10*i]
- ack  out  4  one-hot grant to input i, registered
- pkto  out  10  registered output flit to link
- gnt  out  2  index of currently/last granted input
- busy  out  1  1 while in GRANT state

Behaviour:
- Reset (rst=0, async): state=IDLE, ack=0000, pkto=0, gnt=0, busy=0, round-robin pointer ptr=0. Takes effect immediately, including mid-packet. The packet in flight is dropped, with no tail emitted.
- States: IDLE, GRANT.
- IDLE: pkto<=0 each cycle.
  - If req!=0 at an edge: select first set bit searching ptr, ptr+1, … mod 4.
  - Same edge: gnt<=sel, ack<=onehot(sel), busy<=1, state<=GRANT.
  - Latency: req sampled at edge N gives ack high after edge N.
- GRANT: each edge pkto<=pkti[gnt] unchanged, including 00 idle flits (bubbles), with 1-cycle latency.
  - req is ignored in GRANT. The granted input may drop req without effect.
  - Other inputs' flits, including their tails, are ignored.
- Release: when pkti[gnt][9:8]==11 at an edge in GRANT, that edge does all of:
  - pkto<=tail flit
  - ack<=0000, busy<=0
  - ptr<=(gnt+1) mod 4
  - state<=IDLE
  - gnt is held.
- Back-to-back packets: the earliest next grant is the edge after release. One arbitration bubble cycle between packets is mandatory; pkto=0 in that cycle.
- A head flit (10) seen in GRANT is forwarded as data. No re-arbitration occurs until a tail.
- Requests withdrawn in IDLE before an edge are not granted. Only req at the sampling edge counts.
- Pointer wrap: ptr 3 -> 0.
- Fairness: a continuously requesting input waits at most 3 packets.
- ack is always zero or one-hot. ack!=0 iff busy=1.

Test Plan:
- Reset: hold rst=0 while driving req=1111 and random pkti -> ack=0000, pkto=0, busy=0, gnt=0. Release rst -> port 0 is granted at the first edge (ack=0001).
- Single packet: req=0100. Input 2 drives 10_00000011, 01_00000000, 01_00000001, 11_00000000 on consecutive cycles after ack.
  - Required: ack=0100, gnt=2 one edge after req.
  - The same four flits appear on pkto, each one cycle later.
  - ack=0000 from the edge that registers the tail; next grant starts from port 3.
- Contention: req=1111 held, every packet is head+tail (2 flits) -> grant order 0,1,2,3,0. Each grant is separated by one idle cycle with pkto=0.
- Pointer wrap/priority: after a port 3 packet, req=1001 -> port 0 granted. After a port 0 packet, with req=1001 still held -> port 3 granted.
- Bubbles/isolation: granted input 1 sends head, 00 idle, body, tail, while input 0 drives a tail flit.
  - Required: the idle is forwarded as 0 and no release occurs on input 0's tail.
  - Release happens only on input 1's tail.
- Reset mid-packet: assert rst=0 after head+body of a packet -> ack, pkto, busy clear immediately without waiting for the clock edge. After release, a fresh arbitration starts from ptr=0.

Source files
------------

// File: rtl/oarb.sv
// Output-port arbiter and flit forwarder. One instance sits on each switch
// output. It grants one requesting input round-robin, returns a one-hot ack
// and forwards that input's flits until the tail passes.
module oarb (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [39:0] pkti,
  output logic [3:0]  ack,
  output logic [9:0]  pkto,
  output logic [1:0]  gnt,
  output logic        busy
);

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  localparam logic [1:0] FlitTail = 2'b11;

  state_e     r_state, w_state_nxt;
  logic [3:0] r_ack, w_ack_nxt;
  logic [9:0] r_pkto, w_pkto_nxt;
  logic [1:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic       r_busy, w_busy_nxt;

  logic [7:0] w_req2;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_sel;
  logic [9:0] w_flit;

  assign w_req2 = {req, req};
  // Bit k of w_rot is req[(ptr + k) mod 4], so the lowest set bit is the winner.
  assign w_rot  = w_req2[r_ptr +: 4];

  // Priority-encode the rotated request vector and map back to a port index.
  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    w_sel = r_ptr + w_off;
  end

  // Mux the currently granted input's flit.
  always_comb begin
    w_flit = pkti[9:0];
    unique case (r_gnt)
      2'd0: w_flit = pkti[9:0];
      2'd1: w_flit = pkti[19:10];
      2'd2: w_flit = pkti[29:20];
      2'd3: w_flit = pkti[39:30];
      default: w_flit = pkti[9:0];
    endcase
  end

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_pkto_nxt  = r_pkto;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    unique case (r_state)
      StIdle: begin
        w_pkto_nxt = 10'd0;
        if (req != 4'b0000) begin
          w_gnt_nxt   = w_sel;
          w_ack_nxt   = 4'b0001 << w_sel;
          w_busy_nxt  = 1'b1;
          w_state_nxt = StGrant;
        end
      end
      StGrant: begin
        // Forward verbatim, bubbles and stray heads included.
        w_pkto_nxt = w_flit;
        if (w_flit[9:8] == FlitTail) begin
          w_ack_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_gnt + 2'd1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register; reset drops any packet in flight without a tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_ack   <= 4'b0000;
      r_pkto  <= 10'd0;
      r_gnt   <= 2'd0;
      r_ptr   <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_pkto  <= w_pkto_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign ack  = r_ack;
  assign pkto = r_pkto;
  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule

// File: tb/tb_oarb.sv
// Bench for oarb: directed packets push expected grants and flits into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_oarb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] pkti;
  logic [3:0]  ack;
  logic [9:0]  pkto;
  logic [1:0]  gnt;
  logic        busy;

  oarb dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .pkti (pkti),
    .ack  (ack),
    .pkto (pkto),
    .gnt  (gnt),
    .busy (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_gnt[$];
  logic [9:0] exp_flit[$];
  logic prev_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a rising busy is a grant, a non-zero pkto is a forwarded flit.
  always @(negedge clk) begin
    int g;
    logic [9:0] f;
    if (busy && !prev_busy) begin
      n_checks++;
      if (exp_gnt.size() == 0) begin
        n_errors++;
        $display("FAIL grant_unexpected: got gnt=%0d ack=%b expected no grant", gnt, ack);
      end else begin
        g = exp_gnt.pop_front();
        chk("grant_gnt", 32'(gnt), 32'(g));
        chk("grant_ack", 32'(ack), 32'(4'b0001 << g));
      end
    end
    if (pkto != 10'd0) begin
      n_checks++;
      if (exp_flit.size() == 0) begin
        n_errors++;
        $display("FAIL flit_unexpected: got pkto=%b expected none", pkto);
      end else begin
        f = exp_flit.pop_front();
        chk("flit", 32'(pkto), 32'(f));
      end
    end
    chk("ack_iff_busy", 32'(ack != 4'b0000), 32'(busy));
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    prev_busy <= busy;
  end

  // Expects a grant of port at the next edge, then plays n flits on it.
  task automatic run_pkt(input int port, input int n, input logic [9:0] f0,
                         input logic [9:0] f1, input logic [9:0] f2,
                         input logic [9:0] f3, input logic [3:0] req_after);
    logic [9:0] fl[4];
    fl[0] = f0; fl[1] = f1; fl[2] = f2; fl[3] = f3;
    exp_gnt.push_back(port);
    tick();
    chk("grant_latency", 32'(busy), 32'd1);
    chk("arb_bubble", 32'(pkto), 32'd0);
    req = req_after;
    for (int i = 0; i < n; i++) begin
      pkti[10*port +: 10] = fl[i];
      if (fl[i] != 10'd0) exp_flit.push_back(fl[i]);
      tick();
      if (fl[i] == 10'd0) chk("idle_fwd", 32'(pkto), 32'd0);
      if (i < n - 1) begin
        chk("hold_busy", 32'(busy), 32'd1);
      end else begin
        chk("release_ack", 32'(ack), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
      end
    end
    pkti[10*port +: 10] = 10'd0;
  endtask

  initial begin
    logic [63:0] rnd;
    rst  = 1'b1;
    req  = 4'b0000;
    pkti = '0;
    #2 rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      rnd  = {$urandom, $urandom};
      pkti = rnd[39:0];
      tick();
    end
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_pkto", 32'(pkto), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    pkti = '0;
    rst  = 1'b1;

    // Contention: order 0,1,2,3,0 with head+tail packets.
    run_pkt(0, 2, 10'b1000000001, 10'b1100000001, 10'd0, 10'd0, 4'b1111);
    run_pkt(1, 2, 10'b1000000010, 10'b1100000010, 10'd0, 10'd0, 4'b1111);
    run_pkt(2, 2, 10'b1000000011, 10'b1100000011, 10'd0, 10'd0, 4'b1111);
    run_pkt(3, 2, 10'b1000000100, 10'b1100000100, 10'd0, 10'd0, 4'b1111);
    run_pkt(0, 2, 10'b1000000101, 10'b1100000101, 10'd0, 10'd0, 4'b0100);
    // Single packet on input 2.
    run_pkt(2, 4, 10'b1000000011, 10'b0100000000, 10'b0100000001, 10'b1100000000,
            4'b1001);
    // Pointer wrap: ptr=3 -> 3, then 0, then 3 again.
    run_pkt(3, 2, 10'b1000000110, 10'b1100000110, 10'd0, 10'd0, 4'b1001);
    run_pkt(0, 2, 10'b1000000111, 10'b1100000111, 10'd0, 10'd0, 4'b1001);
    run_pkt(3, 2, 10'b1000001000, 10'b1100001000, 10'd0, 10'd0, 4'b0010);
    // Bubble forwarding while input 0 drives a stray tail.
    pkti[9:0] = 10'b1101010101;
    run_pkt(1, 4, 10'b1000010001, 10'd0, 10'b0100010010, 10'b1100010011, 4'b0000);
    pkti[9:0] = 10'd0;
    tick();
    tick();
    chk("no_req_idle", 32'(busy), 32'd0);

    // Reset mid-packet: ptr=2 now, req=0001 grants port 0.
    req = 4'b0001;
    exp_gnt.push_back(0);
    tick();
    req = 4'b0000;
    pkti[9:0] = 10'b1000100001;
    exp_flit.push_back(10'b1000100001);
    tick();
    pkti[9:0] = 10'b0100100010;
    exp_flit.push_back(10'b0100100010);
    tick();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_ack", 32'(ack), 32'd0);
    chk("async_pkto", 32'(pkto), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_gnt", 32'(gnt), 32'd0);
    pkti = '0;
    tick();
    rst = 1'b1;
    // ptr back at 0: req=1010 grants 1, not 3.
    req = 4'b1010;
    run_pkt(1, 2, 10'b1000110001, 10'b1100110001, 10'd0, 10'd0, 4'b0000);
    tick();
    tick();
    chk("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
    chk("flit_queue_empty", 32'(exp_flit.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
